bgr_startup_seq: RTL and testbench

Digital start-up sequencer that drives the `porst` kick input of the bandgap reference top and qualifies its output before releasing it to the rest of the chip. It pulses `porst`, waits a settling interval, then confirms through a synchronized `vbg_ok` comparator flag that `vbg` is in range. It retries a bounded number of times before declaring a fault. It sits directly upstream of the bandgap top and owns its only control input.

---
 rtl/bgr_startup_seq.sv | 156 +++++++++++++++
 tb/tb_bgr_startup_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bgr_startup_seq.sv
// Start-up sequencer for the bandgap reference: kicks porst, waits for settling, qualifies
// the synchronized vbg_ok flag, and retries a bounded number of times before faulting.
module bgr_startup_seq #(
  parameter int unsigned PULSE_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned CHECK_CYCLES  = 64,
  parameter int unsigned DROP_CYCLES   = 4,
  parameter int unsigned MAX_RETRIES   = 3,
  localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              vbg_ok,
  output logic              porst,
  output logic              bgr_ready,
  output logic              fault,
  output logic [RetryW-1:0] retry_cnt,
  output logic [2:0]        state
);

  localparam int unsigned TimeoutCycles = 2 * CHECK_CYCLES;
  localparam int unsigned MaxPs  = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CntMax = (MaxPs > TimeoutCycles) ? MaxPs : TimeoutCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned GoodW  = $clog2(CHECK_CYCLES + 1);
  localparam int unsigned BadW   = $clog2(DROP_CYCLES + 1);

  localparam logic [CntW-1:0]   PulseLast   = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0]   SettleLast  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(TimeoutCycles - 1);
  localparam logic [GoodW-1:0]  GoodTarget  = GoodW'(CHECK_CYCLES);
  localparam logic [BadW-1:0]   BadTarget   = BadW'(DROP_CYCLES);
  localparam logic [RetryW-1:0] MaxRetry    = RetryW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StKick   = 3'd1,
    StSettle = 3'd2,
    StCheck  = 3'd3,
    StReady  = 3'd4,
    StFault  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [GoodW-1:0]  good_q, good_d, good_nxt;
  logic [BadW-1:0]   bad_q, bad_d, bad_nxt;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              sync_q, ok_s;
  logic              porst_q, ready_q, fault_q;
  logic              take_retry;

  // Saturating run-length counters of good / bad synchronized samples.
  always_comb begin
    good_nxt = '0;
    if (ok_s) good_nxt = (good_q == GoodTarget) ? good_q : good_q + GoodW'(1);
    bad_nxt = '0;
    if (!ok_s) bad_nxt = (bad_q == BadTarget) ? bad_q : bad_q + BadW'(1);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    good_d     = '0;
    bad_d      = '0;
    retry_d    = retry_q;
    take_retry = 1'b0;

    unique case (state_q)
      StIdle: begin
        retry_d = '0;
        if (enable) state_d = StKick;
      end
      StKick: begin
        if (cnt_q == PulseLast) state_d = StSettle;
        else                    cnt_d   = cnt_q + CntW'(1);
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          // The sample taken on the CHECK entry edge already counts toward qualification.
          good_d  = good_nxt;
          state_d = (good_nxt == GoodTarget) ? StReady : StCheck;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCheck: begin
        good_d = good_nxt;
        if (good_nxt == GoodTarget) state_d    = StReady;
        else if (cnt_q == TimeoutLast) take_retry = 1'b1;
        else                           cnt_d      = cnt_q + CntW'(1);
      end
      StReady: begin
        bad_d = bad_nxt;
        if (bad_nxt == BadTarget) take_retry = 1'b1;
      end
      StFault: ;
      default: state_d = StIdle;
    endcase

    if (take_retry) begin
      good_d = '0;
      bad_d  = '0;
      if (retry_q < MaxRetry) begin
        state_d = StKick;
        retry_d = retry_q + RetryW'(1);
      end else begin
        state_d = StFault;
      end
    end

    // Dropping enable aborts from anywhere, including mid-kick.
    if (!enable && state_q != StIdle) begin
      state_d = StIdle;
      cnt_d   = '0;
      good_d  = '0;
      bad_d   = '0;
      retry_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      retry_q <= '0;
      sync_q  <= 1'b0;
      ok_s    <= 1'b0;
      porst_q <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      retry_q <= retry_d;
      sync_q  <= vbg_ok;
      ok_s    <= sync_q;
      // Outputs decode the next state so they move on the same edge as the transition.
      porst_q <= (state_d == StKick);
      ready_q <= (state_d == StReady);
      fault_q <= (state_d == StFault);
    end
  end

  assign porst     = porst_q;
  assign bgr_ready = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_bgr_startup_seq.sv
// Directed bench for bgr_startup_seq with small parameters; expected values are hand-derived
// edge numbers counted from the edge where enable is first sampled high.
module tb_bgr_startup_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       vbg_ok;
  logic       porst;
  logic       bgr_ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  bgr_startup_seq #(
    .PULSE_CYCLES (4),
    .SETTLE_CYCLES(16),
    .CHECK_CYCLES (8),
    .DROP_CYCLES  (4),
    .MAX_RETRIES  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .vbg_ok   (vbg_ok),
    .porst    (porst),
    .bgr_ready(bgr_ready),
    .fault    (fault),
    .retry_cnt(retry_cnt),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s @edge %0d: observed=%0d expected=%0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic step_to(input int n);
    while (edge_n < n) step();
  endtask

  initial begin
    int  pulses;
    int  budget;
    logic prev_porst;

    // Reset with enable and vbg_ok high.
    rst_n  = 1'b0;
    enable = 1'b1;
    vbg_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_porst", 8'(porst), 8'd0);
      chk("rst_ready", 8'(bgr_ready), 8'd0);
      chk("rst_fault", 8'(fault), 8'd0);
      chk("rst_retry", 8'(retry_cnt), 8'd0);
      chk("rst_state", 8'(state), 8'd0);
    end

    // Nominal start-up.
    enable = 1'b0;
    rst_n  = 1'b1;
    repeat (3) step();
    enable = 1'b1;
    edge_n = -1;
    step();
    chk("nom_state_kick", 8'(state), 8'd1);
    for (int i = 0; i < 4; i++) begin
      step_to(i);
      chk("nom_porst_hi", 8'(porst), 8'd1);
    end
    step_to(4);
    chk("nom_porst_lo", 8'(porst), 8'd0);
    chk("nom_state_settle", 8'(state), 8'd2);
    step_to(19);
    chk("nom_state_19", 8'(state), 8'd2);
    step_to(20);
    chk("nom_state_check", 8'(state), 8'd3);
    step_to(26);
    chk("nom_ready_26", 8'(bgr_ready), 8'd0);
    step_to(27);
    chk("nom_ready_27", 8'(bgr_ready), 8'd1);
    chk("nom_state_ready", 8'(state), 8'd4);
    chk("nom_retry", 8'(retry_cnt), 8'd0);

    // Single-cycle ok_s glitch during CHECK at edge 25.
    enable = 1'b0;
    step();
    chk("glitch_idle", 8'(state), 8'd0);
    enable = 1'b1;
    edge_n = -1;
    step_to(22);
    vbg_ok = 1'b0;
    step();
    vbg_ok = 1'b1;
    step_to(27);
    chk("glitch_ready_27", 8'(bgr_ready), 8'd0);
    chk("glitch_state_27", 8'(state), 8'd3);
    step_to(32);
    chk("glitch_ready_32", 8'(bgr_ready), 8'd0);
    step_to(33);
    chk("glitch_ready_33", 8'(bgr_ready), 8'd1);
    chk("glitch_retry", 8'(retry_cnt), 8'd0);

    // Drop while READY: 3 low cycles tolerated, 4 trigger a re-kick.
    vbg_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drop3_ready", 8'(bgr_ready), 8'd1);
    end
    vbg_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("drop3_ready_after", 8'(bgr_ready), 8'd1);
    end
    vbg_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drop4_ready_early", 8'(bgr_ready), 8'd1);
    end
    vbg_ok = 1'b1;
    step();
    chk("drop4_ready_3rd", 8'(bgr_ready), 8'd1);
    step();
    chk("drop4_ready_fall", 8'(bgr_ready), 8'd0);
    chk("drop4_porst", 8'(porst), 8'd1);
    chk("drop4_retry", 8'(retry_cnt), 8'd1);
    chk("drop4_state", 8'(state), 8'd1);

    // Reference never comes up: three pulses, then FAULT.
    enable = 1'b0;
    vbg_ok = 1'b0;
    repeat (3) step();
    chk("nofix_idle_retry", 8'(retry_cnt), 8'd0);
    enable     = 1'b1;
    pulses     = 0;
    prev_porst = 1'b0;
    budget     = 400;
    while (state != 3'd5 && budget > 0) begin
      step();
      if (porst && !prev_porst) pulses++;
      prev_porst = porst;
      budget--;
    end
    chk("nofix_timeout", 8'(budget > 0), 8'd1);
    chk("nofix_pulses", 8'(pulses), 8'd3);
    chk("nofix_retry", 8'(retry_cnt), 8'd2);
    chk("nofix_fault", 8'(fault), 8'd1);
    chk("nofix_porst", 8'(porst), 8'd0);
    chk("nofix_ready", 8'(bgr_ready), 8'd0);
    repeat (3) step();
    chk("nofix_sticky_state", 8'(state), 8'd5);
    chk("nofix_sticky_fault", 8'(fault), 8'd1);
    enable = 1'b0;
    step();
    chk("nofix_clr_state", 8'(state), 8'd0);
    chk("nofix_clr_fault", 8'(fault), 8'd0);
    chk("nofix_clr_retry", 8'(retry_cnt), 8'd0);

    // Abort in SETTLE via enable, then reset mid-kick.
    vbg_ok = 1'b1;
    enable = 1'b1;
    edge_n = -1;
    step_to(9);
    chk("abort_settle_pre", 8'(state), 8'd2);
    enable = 1'b0;
    step();
    chk("abort_settle_state", 8'(state), 8'd0);
    chk("abort_settle_porst", 8'(porst), 8'd0);
    enable = 1'b1;
    edge_n = -1;
    step();
    chk("abort_kick_porst0", 8'(porst), 8'd1);
    step();
    rst_n = 1'b0;
    step();
    chk("abort_rst_porst", 8'(porst), 8'd0);
    chk("abort_rst_state", 8'(state), 8'd0);
    rst_n  = 1'b1;
    edge_n = -1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("restart_porst_hi", 8'(porst), 8'd1);
    end
    step();
    chk("restart_porst_lo", 8'(porst), 8'd0);
    chk("restart_state", 8'(state), 8'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
